// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// rtl/ysyx_22040759_mem_arbiter_pkg.sv - shared encodings and widths for the IF/MEM memory arbiter
package ysyx_22040759_mem_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MS = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_22040759_arb_prio.sv
// rtl/ysyx_22040759_arb_prio.sv - MEM-priority winner select with IF starvation guard
module ysyx_22040759_arb_prio #(
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic ms_req,
  output logic if_win,
  output logic ms_win
);

  localparam int SW = $clog2(MAX_MEM_STREAK + 1);

  logic [SW-1:0] streak;
  logic          at_limit;

  // MEM wins unless IF has waited through MAX_MEM_STREAK consecutive MEM grants
  always_comb begin
    at_limit = (streak == SW'(MAX_MEM_STREAK));
    ms_win   = en && ms_req && !(if_req && at_limit);
    if_win   = en && if_req && !ms_win;
  end

  // Count MEM grants taken while IF was waiting; any IF grant or uncontested MEM grant restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (ms_win) begin
      if (!if_req)
        streak <= '0;
      else if (!at_limit)
        streak <= streak + 1'b1;
    end else if (if_win) begin
      streak <= '0;
    end
  end

endmodule

// File: rtl/ysyx_22040759_mem_arbiter.sv
// rtl/ysyx_22040759_mem_arbiter.sv - single-outstanding arbiter of the shared memory port for IF and MEM
module ysyx_22040759_mem_arbiter
  import ysyx_22040759_mem_arbiter_pkg::*;
#(
  parameter int MAX_MEM_STREAK = 4,
  parameter int ADDR_W = ysyx_22040759_mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ysyx_22040759_mem_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ms_req,
  input  logic              ms_wen,
  input  logic [ADDR_W-1:0] ms_addr,
  input  logic [DATA_W-1:0] ms_wdata,
  input  logic [7:0]        ms_wstrb,
  output logic              ms_gnt,
  output logic              ms_rvalid,
  output logic [DATA_W-1:0] ms_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nxt;
  owner_t            owner;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;
  logic              sel_hi_q;
  logic              discard_q;
  logic              arb_en;
  logic              if_win, ms_win;

  // Arbitration is only open in IDLE; a flush hides the fetch request for that cycle
  assign arb_en = (state == S_IDLE) && !rst;

  ysyx_22040759_arb_prio #(
    .MAX_MEM_STREAK(MAX_MEM_STREAK)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .if_req (if_req && !if_flush),
    .ms_req (ms_req),
    .if_win (if_win),
    .ms_win (ms_win)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, grants, request valid and response pulses
  always_comb begin
    state_nxt     = state;
    if_gnt        = 1'b0;
    ms_gnt        = 1'b0;
    mem_req_valid = 1'b0;
    if_rvalid     = 1'b0;
    ms_rvalid     = 1'b0;
    case (state)
      S_IDLE: begin
        if_gnt = if_win;
        ms_gnt = ms_win;
        if (if_win || ms_win) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_nxt = S_IDLE;
          if (owner == OWN_MS) ms_rvalid = 1'b1;
          else                 if_rvalid = !discard_q && !if_flush;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's request and track whether a squashed fetch must be dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_IF;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      sel_hi_q  <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      if (ms_win) begin
        owner    <= OWN_MS;
        wen_q    <= ms_wen;
        addr_q   <= ms_addr;
        wdata_q  <= ms_wdata;
        wstrb_q  <= ms_wstrb;
        sel_hi_q <= 1'b0;
      end else if (if_win) begin
        owner    <= OWN_IF;
        wen_q    <= 1'b0;
        addr_q   <= if_addr;
        wdata_q  <= '0;
        wstrb_q  <= '0;
        sel_hi_q <= if_addr[2];
      end
      if (state == S_WAIT && mem_resp_valid)
        discard_q <= 1'b0;
      else if (state != S_IDLE && owner == OWN_IF && if_flush)
        discard_q <= 1'b1;
    end
  end

  // Downstream fields are only driven while the request is presented
  assign mem_wen   = mem_req_valid & wen_q;
  assign mem_addr  = mem_req_valid ? addr_q  : '0;
  assign mem_wdata = mem_req_valid ? wdata_q : '0;
  assign mem_wstrb = mem_req_valid ? wstrb_q : '0;

  assign if_rdata = !if_rvalid ? 32'd0 : (sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0]);
  assign ms_rdata = ms_rvalid ? mem_rdata : '0;

endmodule

// File: doc/ysyx_22040759_mem_arbiter.md
Name: ysyx_22040759_mem_arbiter

Overview:
- Arbitrates the single shared memory port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between the IF/MEM pipeline stages and the unified memory/bus interface.
- Allows one outstanding transaction at a time.
- MEM has priority, with a starvation guard for IF; supports squashing an in-flight fetch on branch redirect.

Parameters:
- MAX_MEM_STREAK, 4: consecutive MEM grants allowed while IF is waiting, before IF is forced a grant.
- ADDR_W, 64: address width.
- DATA_W, 64: memory data width (fixed at 64 in this revision).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  64  fetch address, 4-byte aligned
- if_flush  in  1  squash current/pending fetch (branch taken)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  32  instruction word
- ms_req  in  1  data request; held until ms_gnt
- ms_wen  in  1  1 = store, 0 = load
- ms_addr  in  64  data address
- ms_wdata  in  64  store data
- ms_wstrb  in  8  byte enables
- ms_gnt  out  1  data request accepted this cycle
- ms_rvalid  out  1  load data valid or store ack, 1-cycle pulse
- ms_rdata  out  64  load data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_wen  out  1  downstream write
- mem_addr  out  64  downstream address
- mem_wdata  out  64  downstream write data
- mem_wstrb  out  8  downstream byte enables
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  64  downstream read data

Behaviour:
- Reset (async, rst=1):
  - State IDLE; owner, discard flag and streak counter cleared.
  - All outputs 0.
  - Reset mid-transaction abandons the transaction; the downstream shares the same rst.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Combinational arbitration.
  - Winner rule: MEM wins if ms_req, unless if_req is high and streak == MAX_MEM_STREAK, in which case IF wins. IF wins if only if_req is high.
  - if_flush=1 masks if_req in that cycle.
  - The winner's gnt is asserted combinationally in the same cycle.
  - On the clock edge: latch owner, wen, addr, wdata, wstrb (wen=0 and wstrb=0 for IF), and if_addr[2]; go to ISSUE.
- ISSUE:
  - mem_req_valid=1, driven from the latched fields.
  - Fields stay stable until mem_req_ready.
  - On ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, pulse the owner's rvalid in the same cycle (combinational pass-through), then go to IDLE.
  - mem_resp_valid outside WAIT is ignored.
- if_rdata = latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- ms_rdata = mem_rdata.
- rdata outputs are 0 when the matching rvalid is 0.
- Minimum cycle count per transaction (ready and response immediate):
  - Cycle 0: gnt.
  - Cycle 1: ISSUE, accepted.
  - Cycle 2: rvalid.
  - Cycle 3: next grant possible.
- Streak counter:
  - +1 on each MEM grant while if_req=1, saturating at MAX_MEM_STREAK.
  - Cleared on an IF grant, and on a MEM grant while if_req=0.
- Flush:
  - if_flush while owner=IF in ISSUE or WAIT sets the discard flag.
  - The downstream transaction still completes.
  - if_rvalid is suppressed on completion; the flag clears on return to IDLE.
  - Flush while owner=MEM has no effect.
- Simultaneous if_flush and mem_resp_valid in WAIT with owner=IF: the response is discarded.
- No gnt is issued outside IDLE. Requesters keep req high until their gnt.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/ISSUE/WAIT).
  - Owner encoding (OWN_IF, OWN_MS).
  - Width constants ADDR_W and DATA_W.
- One natural sub-module: ysyx_22040759_arb_prio. It is the combinational winner select plus the saturating streak counter.

Test Plan:
- IF-only fetch: if_req=1, if_addr=0x80000004; ready and response immediate; mem_rdata=0x11112222_33334444 → if_gnt in cycle 0; mem_req_valid in cycle 1 with mem_addr=0x80000004 and mem_wen=0; if_rvalid in cycle 2 with if_rdata=0x11112222.
- Simultaneous requests: if_req and ms_req high in the same IDLE cycle with ms_wen=1, ms_wstrb=0xFF → ms_gnt first with mem_wen=1; if_gnt at cycle 3 after ms_rvalid.
- Starvation guard: ms_req held high continuously with if_req=1, MAX_MEM_STREAK=4 → four ms_gnt pulses, then one if_gnt, then MEM resumes.
- Flush: IF granted; mem_req_ready held low 3 cycles; if_flush pulsed in ISSUE; response 0xDEADBEEF → mem transaction completes; if_rvalid stays 0; FSM back in IDLE.
- Backpressure and latency: ms load with mem_req_ready low 5 cycles and response 4 cycles after acceptance → mem_addr/mem_wdata stable throughout; ms_rvalid is a single pulse carrying mem_rdata.
- Async reset: rst asserted in WAIT between clock edges → all outputs 0 immediately; after release, a new if_req is granted in its first IDLE cycle.
